// File: rtl/mult_seq_ctrl.sv
// Shift-and-add multiply sequencer driving an external WIDTH-bit adder.
// One adder pass per RUN cycle; product is latched on the edge that enters DONE.
//
// state | meaning
// IDLE  | waiting for start; adder operands forced to zero
// RUN   | one shift-and-add pass per cycle, cnt passes remaining
// DONE  | one-cycle done pulse; start here launches the next multiply
module mult_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_x,
  output logic [WIDTH-1:0]     add_y,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   m_q, q_q, acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               load, step, last;

  assign last = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        step  = 1'b1;
        add_x = acc_q;
        add_y = q_q[0] ? m_q : '0;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Carry-out becomes the new accumulator MSB, so the 2*WIDTH result never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else if (load) begin
      m_q   <= a;
      q_q   <= b;
      acc_q <= '0;
      cnt_q <= CNT_W'(WIDTH);
    end else if (step) begin
      acc_q <= {add_cout, add_s[WIDTH-1:1]};
      q_q   <= {add_s[0], q_q[WIDTH-1:1]};
      cnt_q <= cnt_q - CNT_W'(1);
      if (last) product <= {add_cout, add_s, q_q[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with an ideal adder attached and a
// cycle-level behavioural model (remaining-cycles counter plus a*b).
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        busy, done;
  logic [15:0] product;
  logic [7:0]  add_x, add_y, add_s;
  logic        add_cin, add_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'h00, add_cin};

  mult_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a multiply occupies 8 busy cycles, then one done cycle.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_pending = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_prod = '0; m_pending = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_prod = m_pending;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_left    = 8;
        m_pending = {8'h00, a} * {8'h00, b};
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_done));
    check("product", 32'(product), 32'(m_prod));
    check("add_cin", 32'(add_cin), 32'd0);
    if (m_left == 0) check("add_xy_idle", {16'h0, add_x, add_y}, 32'd0);
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Pulse start from idle, measure latency and busy length, then check the product.
  task automatic do_mul(input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp, input string name);
    int n, nb;
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; nb = 0;
    while (!done && n < 30) begin
      if (busy) nb++;
      @(posedge clk); #1; n++;
    end
    check({name, "_latency"}, 32'(n), 32'd9);
    check({name, "_busy_len"}, 32'(nb), 32'd8);
    check({name, "_product"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int n;
    logic [7:0] x, y;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;

    do_mul(8'd13, 8'd11, 16'h008F, "m13x11");
    do_mul(8'd255, 8'd255, 16'hFE01, "m255x255");
    do_mul(8'd0, 8'd200, 16'h0000, "m0x200");
    do_mul(8'd200, 8'd0, 16'h0000, "m200x0");
    do_mul(8'd1, 8'd255, 16'h00FF, "m1x255");

    // Start pulsed mid-run with other operands must be ignored.
    wait_idle();
    @(posedge clk); #1; start = 1'b1; a = 8'd13; b = 8'd11;
    @(posedge clk); #1; start = 1'b0; a = 8'd99; b = 8'd77;
    repeat (2) @(posedge clk); #1;
    start = 1'b1; a = 8'd2; b = 8'd2;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!done && n < 30) begin @(posedge clk); #1; n++; end
    check("ignored_start_product", 32'(product), 32'h008F);
    @(posedge clk); #1;
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Asynchronous reset at +4 of a run.
    wait_idle();
    @(posedge clk); #1; start = 1'b1; a = 8'd13; b = 8'd11;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    do_mul(8'd1, 8'd255, 16'h00FF, "after_abort");

    // Back-to-back start in the DONE cycle.
    do_mul(8'd13, 8'd11, 16'h008F, "b2b_first");
    start = 1'b1; a = 8'd3; b = 8'd5;
    @(posedge clk); #1; start = 1'b0;
    n = 1;
    while (!done && n < 30) begin @(posedge clk); #1; n++; end
    check("b2b_latency", 32'(n), 32'd9);
    check("b2b_product", 32'(product), 32'h000F);

    // Start held high: one multiply per 9 cycles, model tracks each.
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      if (done) n++;
    end
    start = 1'b0;
    check("continuous_done_count", 32'(n), 32'd4);

    // Random operands, occasionally with spurious start pulses while busy.
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      wait_idle();
      @(posedge clk); #1; start = 1'b1; a = x; b = y;
      @(posedge clk); #1; start = 1'b0;
      n = 1;
      while (!done && n < 30) begin
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1; a = 8'($urandom); b = 8'($urandom);
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1; n++;
      end
      start = 1'b0;
      check("rand_latency", 32'(n), 32'd9);
      check("rand_product", 32'(product), 32'({8'h00, x} * {8'h00, y}));
    end

    repeat (12) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
